// File: rtl/matrix_feed_pkg.sv
// Shared definitions for the matrix-add row feeder.
// Holds the default geometry (element width, lanes per row, rows per matrix),
// the derived counter widths and the per-buffer state encoding.
package matrix_feed_pkg;

  localparam int IN_WIDTH_DEF = 16;
  localparam int COLS_DEF     = 6;
  localparam int ROWS_DEF     = 10;
  localparam int ROW_W        = $clog2(ROWS_DEF);
  localparam int COL_W        = $clog2(COLS_DEF);

  // Lifecycle of one row buffer: EMPTY -> FILLING -> FULL -> EMPTY.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } bufState_t;

endpackage

// File: rtl/matrix_add_row_feeder_if.sv
// Element-pair stream into the row feeder.
// Signals: s_valid / s_ready handshake, s_a / s_b element pair (row-major),
// s_last marking the final element of a matrix.
// Handshake: a pair transfers on a rising clk edge where s_valid and s_ready
// are both high. While s_valid is high the source holds s_a, s_b and s_last
// stable until that transfer. s_ready does not depend on s_valid.
interface matrix_add_row_feeder_if
  import matrix_feed_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF
) ();

  logic                s_valid;
  logic                s_ready;
  logic [IN_WIDTH-1:0] s_a;
  logic [IN_WIDTH-1:0] s_b;
  logic                s_last;

  modport master (output s_valid, s_a, s_b, s_last, input s_ready);
  modport slave  (input s_valid, s_a, s_b, s_last, output s_ready);

endinterface

// File: rtl/row_pingpong_buffer.sv
// Two COLS-lane A/B row buffers used ping-pong: one fills while the other
// waits for (or undergoes) issue.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wrEn                write lane wrLane of the fill buffer with wrA/wrB
//   wrLane, wrA, wrB    lane index and element pair
//   wrRow               row index tagged onto the fill buffer
//   wrClose             this write completes the fill buffer (-> FULL)
//   issueEn             the issue buffer is consumed this cycle (-> EMPTY)
//   fillFull/issueFull  FULL flags of the buffer under each pointer
//   issueA/issueB/issueRow  contents and row tag of the issue buffer
//   stateDbg            {state[1], state[0]}
module row_pingpong_buffer
  import matrix_feed_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int RW       = ROW_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [$clog2(COLS)-1:0]  wrLane,
  input  logic [IN_WIDTH-1:0]      wrA,
  input  logic [IN_WIDTH-1:0]      wrB,
  input  logic [RW-1:0]            wrRow,
  input  logic                     wrClose,
  input  logic                     issueEn,
  output logic                     fillFull,
  output logic                     issueFull,
  output logic [COLS*IN_WIDTH-1:0] issueA,
  output logic [COLS*IN_WIDTH-1:0] issueB,
  output logic [RW-1:0]            issueRow,
  output logic [3:0]               stateDbg
);

  localparam int W = COLS * IN_WIDTH;

  bufState_t    state     [2];
  bufState_t    stateNext [2];
  logic         fillPtr;
  logic         issuePtr;
  logic [W-1:0] aBuf      [2];
  logic [W-1:0] bBuf      [2];
  logic [RW-1:0] rowTag   [2];

  // A write never targets a FULL buffer and an issue only targets a FULL
  // buffer, so the two updates below never hit the same entry.
  always_comb begin
    stateNext[0] = state[0];
    stateNext[1] = state[1];
    if (issueEn) stateNext[issuePtr] = BUF_EMPTY;
    if (wrEn)    stateNext[fillPtr]  = wrClose ? BUF_FULL : BUF_FILLING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state[0] <= BUF_EMPTY;
      state[1] <= BUF_EMPTY;
      fillPtr  <= 1'b0;
      issuePtr <= 1'b0;
    end else begin
      state[0] <= stateNext[0];
      state[1] <= stateNext[1];
      if (issueEn)          issuePtr <= ~issuePtr;
      if (wrEn && wrClose)  fillPtr  <= ~fillPtr;
    end
  end

  // The first write into an EMPTY buffer zeroes it, so a row closed early by
  // s_last carries zeros in its unwritten lanes. Data needs no reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      if (state[fillPtr] == BUF_EMPTY) begin
        aBuf[fillPtr] <= '0;
        bBuf[fillPtr] <= '0;
      end
      aBuf[fillPtr][wrLane*IN_WIDTH +: IN_WIDTH] <= wrA;
      bBuf[fillPtr][wrLane*IN_WIDTH +: IN_WIDTH] <= wrB;
      rowTag[fillPtr] <= wrRow;
    end
  end

  assign fillFull  = (state[fillPtr]  == BUF_FULL);
  assign issueFull = (state[issuePtr] == BUF_FULL);
  assign issueA    = aBuf[issuePtr];
  assign issueB    = bBuf[issuePtr];
  assign issueRow  = rowTag[issuePtr];
  assign stateDbg  = {state[1], state[0]};

endmodule

// File: rtl/matrix_add_row_feeder.sv
// Upstream feeder for the lane-parallel matrix adder. Packs a serial A/B
// element-pair stream into COLS-wide rows and issues one row per adder
// handshake, with ping-pong buffering so filling overlaps issuing.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            global advance; low freezes all state
//   s                 element-pair stream (slave side)
//   adder_ready       adder can take a new row
//   in_ready          one-cycle issue strobe to the adder
//   vector_in_series  high from the issue of row 0 through row ROWS-1
//   a_row, b_row      issued row, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   row_no            row index of a_row/b_row
//   frame_err         sticky: s_last disagreed with the element count
//   bufState          buffer states {buf1, buf0}
module matrix_add_row_feeder
  import matrix_feed_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  matrix_add_row_feeder_if.slave    s,
  input  logic                      adder_ready,
  output logic                      in_ready,
  output logic                      vector_in_series,
  output logic [COLS*IN_WIDTH-1:0]  a_row,
  output logic [COLS*IN_WIDTH-1:0]  b_row,
  output logic [$clog2(ROWS)-1:0]   row_no,
  output logic                      frame_err,
  output logic [3:0]                bufState
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [CW-1:0]            col;
  logic [RW-1:0]            fillRow;
  logic                     fillFull;
  logic                     issueFull;
  logic [COLS*IN_WIDTH-1:0] issueA;
  logic [COLS*IN_WIDTH-1:0] issueB;
  logic [RW-1:0]            issueRow;
  logic                     accept;
  logic                     lastCol;
  logic                     lastRow;
  logic                     wrClose;
  logic                     issueFire;
  logic                     inReadyQ;

  // s_ready looks only at registered buffer state, never at this cycle's issue.
  assign s.s_ready = enable & ~reset & ~fillFull;
  assign accept    = s.s_valid & s.s_ready;
  assign lastCol   = (col == CW'(COLS - 1));
  assign lastRow   = (fillRow == RW'(ROWS - 1));
  // s_last closes the current buffer wherever it lands.
  assign wrClose   = lastCol | s.s_last;
  assign issueFire = enable & ~reset & adder_ready & issueFull;

  // The strobe register holds while enable is low, so a strobe raised just
  // before a frozen cycle is presented in the next enabled cycle instead.
  assign in_ready  = inReadyQ & enable;

  row_pingpong_buffer #(
    .IN_WIDTH (IN_WIDTH),
    .COLS     (COLS),
    .RW       (RW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wrEn      (accept),
    .wrLane    (col),
    .wrA       (s.s_a),
    .wrB       (s.s_b),
    .wrRow     (fillRow),
    .wrClose   (wrClose),
    .issueEn   (issueFire),
    .fillFull  (fillFull),
    .issueFull (issueFull),
    .issueA    (issueA),
    .issueB    (issueB),
    .issueRow  (issueRow),
    .stateDbg  (bufState)
  );

  // Column / row fill counters and the s_last framing check.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      fillRow   <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (s.s_last && !(lastCol && lastRow)) begin
        // Early end of matrix: close the partial row and restart at row 0.
        frame_err <= 1'b1;
        col       <= '0;
        fillRow   <= '0;
      end else if (lastCol) begin
        col     <= '0;
        fillRow <= lastRow ? '0 : fillRow + 1'b1;
        if (lastRow && !s.s_last) frame_err <= 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Issue strobe, output row registers and the series flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      inReadyQ         <= 1'b0;
      vector_in_series <= 1'b0;
      a_row            <= '0;
      b_row            <= '0;
      row_no           <= '0;
    end else if (enable) begin
      inReadyQ <= issueFire;
      if (issueFire) begin
        a_row  <= issueA;
        b_row  <= issueB;
        row_no <= issueRow;
      end
      if (issueFire && issueRow == '0)
        vector_in_series <= 1'b1;
      else if (inReadyQ && row_no == RW'(ROWS - 1))
        vector_in_series <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_add_row_feeder.sv
module tb_matrix_add_row_feeder;
  import matrix_feed_pkg::*;

  localparam int IW    = 16;
  localparam int NC    = 6;
  localparam int NR    = 10;
  localparam int RW    = $clog2(NR);
  localparam int W     = NC * IW;
  localparam int EXP_W = RW + 2 * W;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          adder_ready;
  logic          in_ready;
  logic          vector_in_series;
  logic [W-1:0]  a_row;
  logic [W-1:0]  b_row;
  logic [RW-1:0] row_no;
  logic          frame_err;
  logic [3:0]    bufState;

  matrix_add_row_feeder_if #(.IN_WIDTH(IW)) tif ();

  matrix_add_row_feeder #(.IN_WIDTH(IW), .COLS(NC), .ROWS(NR)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .s                (tif),
    .adder_ready      (adder_ready),
    .in_ready         (in_ready),
    .vector_in_series (vector_in_series),
    .a_row            (a_row),
    .b_row            (b_row),
    .row_no           (row_no),
    .frame_err        (frame_err),
    .bufState         (bufState)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests    = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  int strobe_q[$];
  int row_log[$];
  int fall_q[$];
  logic vis_prev = 1'b0;
  bit   toggle_en = 1'b0;
  int   last_acc_cyc = 0;

  // reference row model
  int           m_col = 0;
  int           m_row = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // monitor: pop and compare on every strobe, log strobe/fall cycles
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (in_ready === 1'b1) begin
      strobe_q.push_back(cyc);
      row_log.push_back(int'(row_no));
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("row_data", {row_no, a_row, b_row}, e);
      end
      check("vis_at_strobe", vector_in_series, 1'b1);
    end
    if (vis_prev && !vector_in_series) fall_q.push_back(cyc);
    vis_prev = vector_in_series;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) enable = ~enable;
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    row_log.delete();
    fall_q.delete();
  endtask

  task automatic send(input int a, input int b, input bit last);
    int guard;
    bit acc;
    tif.s_valid = 1'b1;
    tif.s_a     = IW'(a);
    tif.s_b     = IW'(b);
    tif.s_last  = last;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = tif.s_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      tests++;
      failures++;
      $error("FAIL send_timeout observed=no_accept expected=accept a=%0d", a);
    end
    last_acc_cyc = cyc;
    m_a[m_col*IW +: IW] = IW'(a);
    m_b[m_col*IW +: IW] = IW'(b);
    if (last || m_col == NC - 1) begin
      exp_q.push_back({RW'(m_row), m_a, m_b});
      m_a = '0;
      m_b = '0;
      if (last) m_row = 0;
      else      m_row = (m_row == NR - 1) ? 0 : m_row + 1;
      m_col = 0;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle_src();
    tif.s_valid = 1'b0;
    tif.s_last  = 1'b0;
  endtask

  task automatic send_matrix(input int base);
    for (int i = 0; i < NR * NC; i++) send(base + i, -(base + i), i == NR * NC - 1);
    idle_src();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_vis"}, vector_in_series, 1'b0);
    check({tag, "_a_row"}, a_row, '0);
    check({tag, "_b_row"}, b_row, '0);
    check({tag, "_row_no"}, row_no, '0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_buf_state"}, bufState, '0);
  endtask

  task automatic check_spacing(input string tag, input int gap);
    for (int i = 1; i < strobe_q.size(); i++)
      check(tag, strobe_q[i] - strobe_q[i-1], gap);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc5;
    reset = 1'b1; enable = 1'b1; adder_ready = 1'b1;
    tif.s_valid = 1'b0; tif.s_a = '0; tif.s_b = '0; tif.s_last = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", tif.s_ready, 1'b0);
    check_idle("rst");
    reset = 1'b0;
    tick();
    check("post_rst_s_ready", tif.s_ready, 1'b1);
    check_idle("post_rst");

    // 1: one matrix back-to-back, A=i, B=-i
    clear_logs();
    acc5 = 0;
    for (int i = 0; i < NR * NC; i++) begin
      send(i, -i, i == NR * NC - 1);
      if (i == NC - 1) acc5 = last_acc_cyc;
    end
    idle_src();
    wait_drain("t1_drain");
    check("t1_strobes", strobe_q.size(), 10);
    if (strobe_q.size() == 10) begin
      check("t1_latency", strobe_q[0], acc5 + 1);
      check("t1_last_row", row_log[9], 9);
      check("t1_fall", fall_q.size() > 0 ? fall_q[0] : -1, strobe_q[9] + 1);
    end
    check_spacing("t1_spacing", 6);
    check("t1_vis_low", vector_in_series, 1'b0);
    check("t1_frame_err", frame_err, 1'b0);

    // 2: adder stalled, both buffers fill, then release
    clear_logs();
    adder_ready = 1'b0;
    for (int i = 0; i < 2 * NC; i++) send(100 + i, -(100 + i), 1'b0);
    idle_src();
    check("t2_blocked_s_ready", tif.s_ready, 1'b0);
    check("t2_no_strobe", strobe_q.size(), 0);
    adder_ready = 1'b1;
    tick();
    check("t2_issue", in_ready, 1'b1);
    check("t2_row_no", row_no, '0);
    check("t2_s_ready_back", tif.s_ready, 1'b1);
    for (int i = 2 * NC; i < NR * NC; i++) send(100 + i, -(100 + i), i == NR * NC - 1);
    idle_src();
    wait_drain("t2_drain");
    check("t2_strobes", strobe_q.size(), 10);

    // 3: early s_last on pair 33 (row 5, col 3)
    clear_logs();
    for (int i = 0; i < 33; i++) send(1000 + i, -(1000 + i), 1'b0);
    check("t3_no_err_yet", frame_err, 1'b0);
    send(1033, -1033, 1'b1);
    check("t3_frame_err", frame_err, 1'b1);
    for (int i = 0; i < NC; i++) send(2000 + i, -(2000 + i), 1'b0);
    idle_src();
    wait_drain("t3_drain");
    check("t3_strobes", strobe_q.size(), 7);
    if (strobe_q.size() == 7) begin
      check("t3_short_row", row_log[5], 5);
      check("t3_resync_row", row_log[6], 0);
    end
    check("t3_err_sticky", frame_err, 1'b1);

    // 4: reset with row 2 FULL and row 3 half-filled
    clear_logs();
    for (int i = 0; i < 2 * NC + 1; i++) send(3000 + i, -(3000 + i), 1'b0);
    adder_ready = 1'b0;
    for (int i = 2 * NC + 1; i < 3 * NC + 3; i++) send(3000 + i, -(3000 + i), 1'b0);
    idle_src();
    tick();
    check("t4_pre_strobes", strobe_q.size(), 2);
    reset = 1'b1;
    adder_ready = 1'b1;
    exp_q.delete();
    m_col = 0; m_row = 0; m_a = '0; m_b = '0;
    clear_logs();
    repeat (2) tick();
    check("t4_rst_s_ready", tif.s_ready, 1'b0);
    reset = 1'b0;
    repeat (10) tick();
    check("t4_no_strobe", strobe_q.size(), 0);
    check_idle("t4_post");
    check("t4_s_ready", tif.s_ready, 1'b1);
    send_matrix(4000);
    wait_drain("t4_drain");
    check("t4_strobes", strobe_q.size(), 10);
    if (strobe_q.size() == 10) check("t4_first_row", row_log[0], 0);

    // 5: enable toggling every cycle
    clear_logs();
    toggle_en = 1'b1;
    for (int i = 0; i < NR * NC; i++) send(i, -i, i == NR * NC - 1);
    idle_src();
    wait_drain("t5_drain");
    toggle_en = 1'b0;
    enable = 1'b1;
    tick();
    check("t5_strobes", strobe_q.size(), 10);
    check_spacing("t5_spacing", 12);
    check("t5_frame_err", frame_err, 1'b0);

    // 6: two matrices back-to-back
    clear_logs();
    for (int i = 0; i < 2 * NR * NC; i++)
      send(5000 + i, -(5000 + i), (i == NR * NC - 1) || (i == 2 * NR * NC - 1));
    idle_src();
    wait_drain("t6_drain");
    check("t6_strobes", strobe_q.size(), 20);
    if (strobe_q.size() == 20) begin
      check("t6_row9", row_log[9], 9);
      check("t6_row0", row_log[10], 0);
      check("t6_gap", strobe_q[10] - strobe_q[9], 6);
      check("t6_fall_between", fall_q.size() > 0 ? fall_q[0] : -1, strobe_q[9] + 1);
    end
    check("t6_falls", fall_q.size(), 2);
    check("t6_frame_err", frame_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
